goofy_mem_seq: RTL and testbench

- Word-access sequencer directly upstream of the 8-bit-wide byte RAM (64K x byte, combinational read, write on clock falling edge when save strobe high).
- Accepts 16-bit little-endian load/store requests from the CPU core over a valid/ready handshake.
- Splits each request into two byte accesses: low byte at A, high byte at A+1. Returns read data with a one-cycle response pulse.

---
 rtl/goofy_mem_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_goofy_mem_seq.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/goofy_mem_seq.sv
// ---------------------------------------------------------------------------
// goofy_mem_seq
//
// Word-access sequencer sitting directly in front of an 8-bit byte RAM
// (combinational read, write sampled on the falling clock edge while the
// save strobe is high). A 16-bit little-endian load/store from the CPU is
// split into two byte accesses: low byte at A, high byte at A+1 (modulo
// 2^ADDR_W). Completion is signalled with a one-cycle resp_valid pulse.
//
// Sequence: IDLE -> LO -> HI -> DONE -> IDLE. LO and HI each last
// WAIT_STATES+1 cycles. All outputs come straight from flops.
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high. The sequencer latches req_write, req_addr and
// req_wdata on that edge, so the CPU may change them afterwards.
// req_ready is high only in IDLE. resp_valid is a single-cycle pulse with
// no back-pressure; resp_err is meaningful only while resp_valid is high.
//
// Optional build macro: GOOFY_MEMSEQ_WRAP_ERR_EN
//   When defined, a request at A = 2^ADDR_W-1 (the word would wrap) is
//   rejected: no RAM access, resp_valid with resp_err=1, resp_rdata kept.
//   When undefined, such a request wraps to address 0 and resp_err is 0.
//
// Parameters:
//   WAIT_STATES  extra cycles each byte access is held (0..15)
//   ADDR_W       byte address width; RAM holds 2^ADDR_W bytes
//
// Ports:
//   clk          system clock, all state changes on posedge
//   reset        asynchronous, active-high reset
//   req_valid    CPU request present
//   req_ready    sequencer can accept a request (IDLE only)
//   req_write    1 = store word, 0 = load word
//   req_addr     byte address of the low byte
//   req_wdata    store data, [7:0] to A, [15:8] to A+1
//   resp_valid   one-cycle completion pulse
//   resp_rdata   load data, held until the next load completes
//   resp_err     error flag, qualified by resp_valid
//   ram_addr     RAM byte address
//   ram_in       RAM write data
//   sam_save     RAM write strobe (sampled by the RAM on negedge)
//   ram_out      RAM read data, combinational from ram_addr
//   dbg_state    current sequencer state (IDLE=0, LO=1, HI=2, DONE=3)
// ---------------------------------------------------------------------------
module goofy_mem_seq #(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              resp_valid,
    output logic [15:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_in,
    output logic              sam_save,
    input  logic [7:0]        ram_out,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Index of the last cycle of a byte phase.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    state_t            state_q,      state_d;
    logic [3:0]        wait_q,       wait_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic              write_q,      write_d;
    logic [7:0]        wdata_hi_q,   wdata_hi_d;
    logic [7:0]        rdata_lo_q,   rdata_lo_d;
    logic              req_ready_q,  req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [15:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q,   resp_err_d;
    logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
    logic [7:0]        ram_in_q,     ram_in_d;
    logic              sam_save_q,   sam_save_d;

    logic [ADDR_W-1:0] addr_inc;
    logic              wrap_reject;
    logic              phase_last;
    logic              next_is_last;

    // High-byte address; the natural overflow of the adder gives the
    // modulo-2^ADDR_W wrap from the top address to 0.
    assign addr_inc = addr_q + ADDR_W'(1);

`ifdef GOOFY_MEMSEQ_WRAP_ERR_EN
    assign wrap_reject = &req_addr;
`else
    assign wrap_reject = 1'b0;
`endif

    // phase_last: the current cycle is the final one of LO/HI.
    // next_is_last: the cycle after this edge will be the final one of the
    // same phase, so the write strobe must be raised for it now.
    assign phase_last   = (wait_q == WAIT_LAST);
    assign next_is_last = ((wait_q + 4'd1) == WAIT_LAST);

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_hi_d   = wdata_hi_q;
        rdata_lo_d   = rdata_lo_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        ram_addr_d   = ram_addr_q;
        ram_in_d     = ram_in_q;
        sam_save_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d      = req_addr;
                    write_d     = req_write;
                    wdata_hi_d  = req_wdata[15:8];
                    req_ready_d = 1'b0;
                    if (wrap_reject) begin
                        // Rejected word: straight to the response, RAM
                        // outputs untouched.
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d    = ST_LO;
                        wait_d     = 4'd0;
                        ram_addr_d = req_addr;
                        ram_in_d   = req_wdata[7:0];
                        sam_save_d = req_write && (WAIT_LAST == 4'd0);
                    end
                end
            end

            ST_LO: begin
                if (phase_last) begin
                    rdata_lo_d = ram_out;
                    state_d    = ST_HI;
                    wait_d     = 4'd0;
                    ram_addr_d = addr_inc;
                    ram_in_d   = wdata_hi_q;
                    sam_save_d = write_q && (WAIT_LAST == 4'd0);
                end else begin
                    wait_d     = wait_q + 4'd1;
                    sam_save_d = write_q && next_is_last;
                end
            end

            ST_HI: begin
                if (phase_last) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    // Stores leave the previous load result visible.
                    if (!write_q) begin
                        resp_rdata_d = {ram_out, rdata_lo_q};
                    end
                end else begin
                    wait_d     = wait_q + 4'd1;
                    sam_save_d = write_q && next_is_last;
                end
            end

            ST_DONE: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                resp_err_d  = 1'b0;
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // Reset is asynchronous so that a reset landing mid-access drops
    // sam_save before the RAM's next falling-edge sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_q       <= 4'd0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_hi_q   <= 8'd0;
            rdata_lo_q   <= 8'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 16'd0;
            resp_err_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_in_q     <= 8'd0;
            sam_save_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_hi_q   <= wdata_hi_d;
            rdata_lo_q   <= rdata_lo_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ram_addr_q   <= ram_addr_d;
            ram_in_q     <= ram_in_d;
            sam_save_q   <= sam_save_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign ram_addr   = ram_addr_q;
    assign ram_in     = ram_in_q;
    assign sam_save   = sam_save_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_goofy_mem_seq.sv
`timescale 1ns/1ps
module tb_goofy_mem_seq;

  localparam int AW = 16;
`ifdef GOOFY_MEMSEQ_WRAP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // index 0: WAIT_STATES=0 instance, index 1: WAIT_STATES=2 instance
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [15:0] req_addr   [2];
  logic [15:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [15:0] resp_rdata [2];
  logic        resp_err   [2];
  logic [15:0] ram_addr   [2];
  logic [7:0]  ram_in     [2];
  logic        sam_save   [2];
  logic [7:0]  ram_out    [2];
  logic [1:0]  dbg_state  [2];

  logic [7:0]  mem     [2][65536];
  logic [7:0]  ref_mem [2][65536];
  logic [15:0] last_rd [2];

  int n_chk  = 0;
  int n_fail = 0;

  goofy_mem_seq #(.WAIT_STATES(0), .ADDR_W(AW)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .ram_addr(ram_addr[0]), .ram_in(ram_in[0]), .sam_save(sam_save[0]),
    .ram_out(ram_out[0]), .dbg_state(dbg_state[0])
  );

  goofy_mem_seq #(.WAIT_STATES(2), .ADDR_W(AW)) u_dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .ram_addr(ram_addr[1]), .ram_in(ram_in[1]), .sam_save(sam_save[1]),
    .ram_out(ram_out[1]), .dbg_state(dbg_state[1])
  );

  // Byte RAM behaviour: combinational read, write on falling edge.
  assign ram_out[0] = mem[0][ram_addr[0]];
  assign ram_out[1] = mem[1][ram_addr[1]];
  always @(negedge clk) begin
    if (sam_save[0] === 1'b1) mem[0][ram_addr[0]] = ram_in[0];
    if (sam_save[1] === 1'b1) mem[1][ram_addr[1]] = ram_in[1];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  task automatic preload(input int k, input logic [15:0] a, input logic [7:0] d);
    mem[k][a]     = d;
    ref_mem[k][a] = d;
  endtask

  // Reference: what a word access should do, from the word-level rules.
  task automatic model_txn(input int k, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                           output int lat, output int saves, output logic [15:0] rd, output bit err);
    logic [15:0] a1;
    a1  = a + 16'd1;
    err = ERR_EN && (a == 16'hFFFF);
    if (err) begin
      lat   = 1;
      saves = 0;
    end else begin
      lat   = 2 * (ws_of(k) + 1) + 1;
      saves = wr ? 2 : 0;
      if (wr) begin
        ref_mem[k][a]  = wd[7:0];
        ref_mem[k][a1] = wd[15:8];
      end else begin
        last_rd[k] = {ref_mem[k][a1], ref_mem[k][a]};
      end
    end
    rd = last_rd[k];
  endtask

  // Driver + monitor for one transaction on instance k.
  task automatic dut_txn(input int k, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                         output int lat, output int saves, output logic [15:0] rd, output bit err,
                         output int busy_bad, output bit rdy_after);
    int guard;
    int ws;
    logic [15:0] a1;
    ws = ws_of(k);
    a1 = a + 16'd1;
    lat = -1; saves = 0; rd = 16'h0; err = 1'b0; busy_bad = 0; rdy_after = 1'b0;
    req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = a; req_wdata[k] = wd;
    guard = 0;
    while (req_ready[k] !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    step();  // acceptance edge
    // Scramble the request lines: the DUT must work from its latched copy.
    req_valid[k] = 1'b0;
    req_write[k] = 1'($urandom_range(0, 1));
    req_addr[k]  = 16'($urandom);
    req_wdata[k] = 16'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (sam_save[k] === 1'b1) saves++;
      if (req_ready[k] !== 1'b0) busy_bad++;
      if (resp_valid[k] === 1'b1) begin
        lat = c;
        rd  = resp_rdata[k];
        err = resp_err[k];
        break;
      end
      if (c <= ws + 1) begin
        if (ram_addr[k] !== a || ram_in[k] !== wd[7:0]) busy_bad++;
      end else begin
        if (ram_addr[k] !== a1 || ram_in[k] !== wd[15:8]) busy_bad++;
      end
      step();
    end
    step();
    rdy_after = (req_ready[k] === 1'b1) && (resp_valid[k] === 1'b0);
  endtask

  task automatic run_txn(input string tag, input int k, input bit wr,
                         input logic [15:0] a, input logic [15:0] wd);
    int e_lat, e_sv, lat, sv, bb;
    logic [15:0] e_rd, rd;
    bit e_err, err, ra;
    model_txn(k, wr, a, wd, e_lat, e_sv, e_rd, e_err);
    dut_txn(k, wr, a, wd, lat, sv, rd, err, bb, ra);
    check($sformatf("%s.lat", tag), lat, e_lat);
    check($sformatf("%s.saves", tag), sv, e_sv);
    check($sformatf("%s.rdata", tag), 32'(rd), 32'(e_rd));
    check($sformatf("%s.err", tag), 32'(err), 32'(e_err));
    check($sformatf("%s.busy", tag), bb, 0);
    check($sformatf("%s.ready_after", tag), 32'(ra), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag, input int k);
    check($sformatf("%s.req_ready", tag), 32'(req_ready[k]), 32'd1);
    check($sformatf("%s.resp_valid", tag), 32'(resp_valid[k]), 32'd0);
    check($sformatf("%s.resp_rdata", tag), 32'(resp_rdata[k]), 32'd0);
    check($sformatf("%s.resp_err", tag), 32'(resp_err[k]), 32'd0);
    check($sformatf("%s.ram_addr", tag), 32'(ram_addr[k]), 32'd0);
    check($sformatf("%s.ram_in", tag), 32'(ram_in[k]), 32'd0);
    check($sformatf("%s.sam_save", tag), 32'(sam_save[k]), 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          k;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
    int          exp_saves;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, sv, bb, n_acc, n_resp, bad;
    int acc_cyc [3];
    logic [15:0] rd;
    logic [15:0] b2b_addr [3];
    logic [15:0] b2b_data [3];
    int d_lat, d_sv;
    logic [15:0] d_rd;
    bit err, ra, d_err;

    vecs[0] = '{0, 1'b1, 16'h1000, 16'hBEEF, 16'h0000, 1'b0, 3, 2};
    vecs[1] = '{0, 1'b0, 16'h2000, 16'h0000, 16'h1234, 1'b0, 3, 0};
    vecs[2] = '{0, 1'b1, 16'hFFFF, 16'hA55A, 16'h1234, ERR_EN, ERR_EN ? 1 : 3, ERR_EN ? 0 : 2};
    vecs[3] = '{1, 1'b0, 16'h0010, 16'h0000, 16'hABCD, 1'b0, 7, 0};
    vecs[4] = '{1, 1'b1, 16'h0020, 16'h5AA5, 16'hABCD, 1'b0, 7, 2};
    vecs[5] = '{0, 1'b0, 16'h1000, 16'h0000, 16'hBEEF, 1'b0, 3, 0};
    vecs[6] = '{0, 1'b0, 16'hFFFF, 16'h0000, ERR_EN ? 16'hBEEF : 16'hA55A, ERR_EN, ERR_EN ? 1 : 3, 0};

    for (int i = 0; i < 65536; i++) begin
      mem[0][i] = 8'h00; mem[1][i] = 8'h00;
      ref_mem[0][i] = 8'h00; ref_mem[1][i] = 8'h00;
    end
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = 16'h0; req_wdata[k] = 16'h0;
    end

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_reset_outputs("reset0", 0);
    check_reset_outputs("reset2", 1);
    check("reset0.state", 32'(dbg_state[0]), 32'd0);

    preload(0, 16'h2000, 8'h34);
    preload(0, 16'h2001, 8'h12);
    preload(1, 16'h0010, 8'hCD);
    preload(1, 16'h0011, 8'hAB);

    // ---- table-driven directed transactions ----
    foreach (vecs[i]) begin
      dut_txn(vecs[i].k, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, sv, rd, err, bb, ra);
      model_txn(vecs[i].k, vecs[i].wr, vecs[i].addr, vecs[i].wdata, d_lat, d_sv, d_rd, d_err);
      check($sformatf("vec%0d.lat", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d.saves", i), sv, vecs[i].exp_saves);
      check($sformatf("vec%0d.rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d.err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d.busy", i), bb, 0);
      check($sformatf("vec%0d.ready_after", i), 32'(ra), 32'd1);
    end
    check("ram0[1000]", 32'(mem[0][16'h1000]), 32'hEF);
    check("ram0[1001]", 32'(mem[0][16'h1001]), 32'hBE);
    check("ram0[FFFF]", 32'(mem[0][16'hFFFF]), ERR_EN ? 32'h00 : 32'h5A);
    check("ram0[0000]", 32'(mem[0][16'h0000]), ERR_EN ? 32'h00 : 32'hA5);
    check("ram2[0020]", 32'(mem[1][16'h0020]), 32'hA5);
    check("ram2[0021]", 32'(mem[1][16'h0021]), 32'h5A);

    // ---- back-to-back stores with req_valid held high ----
    b2b_addr[0] = 16'h4000; b2b_data[0] = 16'hC0DE;
    b2b_addr[1] = 16'h4002; b2b_data[1] = 16'hF00D;
    b2b_addr[2] = 16'h4004; b2b_data[2] = 16'h1357;
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[0] = b2b_addr[0]; req_wdata[0] = b2b_data[0];
    n_acc = 0; n_resp = 0;
    for (int c = 0; c < 40; c++) begin
      if (resp_valid[0] === 1'b1) n_resp++;
      if (n_acc < 3 && req_ready[0] === 1'b1) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        step();
        if (n_acc < 3) begin
          req_addr[0] = b2b_addr[n_acc]; req_wdata[0] = b2b_data[n_acc];
        end else begin
          req_valid[0] = 1'b0;
        end
      end else begin
        step();
      end
    end
    check("b2b.accepts", n_acc, 3);
    check("b2b.responses", n_resp, 3);
    if (n_acc == 3) begin
      check("b2b.gap01", acc_cyc[1] - acc_cyc[0], 4);
      check("b2b.gap12", acc_cyc[2] - acc_cyc[1], 4);
    end
    for (int j = 0; j < 3; j++) begin
      model_txn(0, 1'b1, b2b_addr[j], b2b_data[j], d_lat, d_sv, d_rd, d_err);
      check($sformatf("b2b.word%0d", j),
            32'({mem[0][b2b_addr[j] + 16'd1], mem[0][b2b_addr[j]]}), 32'(b2b_data[j]));
    end

    // ---- reset during the HI phase of a store ----
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 16'h3000; req_wdata[0] = 16'h1111;
    bad = 0;
    while (req_ready[0] !== 1'b1 && bad < 20) begin step(); bad++; end
    step();                      // accepted; now in LO
    req_valid[0] = 1'b0;
    check("rst.lo_save", 32'(sam_save[0]), 32'd1);
    step();                      // now in HI, low byte already written
    check("rst.hi_addr", 32'(ram_addr[0]), 32'h3001);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst.async", 0);
    step();
    check("rst.ram[3000]", 32'(mem[0][16'h3000]), 32'h11);
    check("rst.ram[3001]", 32'(mem[0][16'h3001]), 32'h00);
    reset = 1'b0;
    ref_mem[0][16'h3000] = 8'h11;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    n_resp = 0;
    repeat (5) begin
      if (resp_valid[0] === 1'b1) n_resp++;
      step();
    end
    check("rst.no_resp", n_resp, 0);
    run_txn("rst.after_st", 0, 1'b1, 16'h3000, 16'h2222);
    run_txn("rst.after_ld", 0, 1'b0, 16'h3000, 16'h0000);

    // ---- randomized traffic against the word-level model ----
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 25; t++) begin
        logic [15:0] a;
        if ($urandom_range(0, 5) == 0) a = 16'hFFFF;
        else if ($urandom_range(0, 2) == 0) a = 16'h5000 + 16'($urandom_range(0, 7));
        else a = 16'($urandom);
        run_txn($sformatf("rnd%0d_%0d", k, t), k, 1'($urandom_range(0, 1)), a, 16'($urandom));
      end
    end

    bad = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 65536; i++)
        if (mem[k][i] !== ref_mem[k][i]) bad++;
    check("mem_image", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
